// File: rtl/ccff_pkg.sv
// Shared types and defaults for the configuration-chain loader.
package ccff_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } ccff_ld_state_t;

  localparam int CCFF_BYTE_W = 8;

endpackage

// File: rtl/ccff_rb_packer.sv
// Serial-in / word-out packer for chain readback; the first bit lands in the MSB.
module ccff_rb_packer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clear,
  input  logic         i_bit_valid,
  input  logic         i_bit,
  input  logic         i_flush,
  output logic [W-1:0] o_data,
  output logic         o_valid
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  r_acc;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  w_acc_next;
  logic [CW-1:0] w_cnt_next;
  logic [CW-1:0] w_pad;

  always_comb begin
    w_acc_next = (r_acc << 1) | W'(i_bit);
    w_cnt_next = r_cnt + 1'b1;
    w_pad      = CW'(W) - w_cnt_next;
  end

  // A partial final word is left-aligned; stale high bits shift out with the pad.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (i_clear) begin
        r_cnt <= '0;
      end else if (i_bit_valid) begin
        r_acc <= w_acc_next;
        if (w_cnt_next == CW'(W)) begin
          o_data  <= w_acc_next;
          o_valid <= 1'b1;
          r_cnt   <= '0;
        end else if (i_flush) begin
          o_data  <= w_acc_next << w_pad;
          o_valid <= 1'b1;
          r_cnt   <= '0;
        end else begin
          r_cnt <= w_cnt_next;
        end
      end
    end
  end

endmodule

// File: rtl/ccff_loader.sv
// Byte-fed serializer for the configuration chain with chain readback packing.
// Handshake: a byte transfers on a prog_clk edge where cfg_valid & cfg_ready are both 1.
module ccff_loader
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN = 20,
  parameter int BYTE_W    = CCFF_BYTE_W
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [BYTE_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              prog_clk_en,
  input  logic              ccff_tail,
  output logic [BYTE_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done,
  output ccff_ld_state_t    o_dbg_state
);

  localparam int N_BYTES = (CHAIN_LEN + BYTE_W - 1) / BYTE_W;
  localparam int BITS_W  = $clog2(CHAIN_LEN + 1);
  localparam int BYTES_W = $clog2(N_BYTES + 1);
  localparam int SC_W    = $clog2(BYTE_W + 1);

  ccff_ld_state_t    r_state, w_next_state;
  logic [BITS_W-1:0]  r_bits;
  logic [BYTES_W-1:0] r_bytes;
  logic [BYTE_W-1:0]  r_hold;
  logic               r_hold_full;
  logic [BYTE_W-1:0]  r_shift;
  logic [SC_W-1:0]    r_sh_cnt;
  logic               r_head_last;

  logic w_sh_has, w_bit, w_en, w_last, w_ready, w_accept, w_start_ok;

  // When the shifter is empty the hold byte's MSB goes out directly as it moves over.
  always_comb begin
    w_sh_has   = (r_sh_cnt != '0);
    w_bit      = w_sh_has ? r_shift[BYTE_W-1] : r_hold[BYTE_W-1];
    w_en       = (r_state == LOAD) && (w_sh_has || r_hold_full);
    w_last     = w_en && (r_bits == BITS_W'(CHAIN_LEN - 1));
    w_ready    = (r_state == LOAD) && !r_hold_full && (r_bytes < BYTES_W'(N_BYTES));
    w_accept   = w_ready && cfg_valid;
    w_start_ok = start && (r_state != LOAD);
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) r_state <= IDLE;
    else            r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start)  w_next_state = LOAD;
      LOAD:    if (w_last) w_next_state = DONE;
      DONE:    if (start)  w_next_state = LOAD;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      r_bits      <= '0;
      r_bytes     <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_shift     <= '0;
      r_sh_cnt    <= '0;
      r_head_last <= 1'b0;
    end else if (w_start_ok) begin
      r_bits      <= '0;
      r_bytes     <= '0;
      r_hold_full <= 1'b0;
      r_sh_cnt    <= '0;
    end else begin
      if (w_en) begin
        r_bits      <= r_bits + 1'b1;
        r_head_last <= w_bit;
        if (w_sh_has) begin
          r_shift  <= r_shift << 1;
          r_sh_cnt <= r_sh_cnt - 1'b1;
        end else begin
          r_shift     <= r_hold << 1;
          r_sh_cnt    <= SC_W'(BYTE_W - 1);
          r_hold_full <= 1'b0;
        end
      end
      if (w_accept) begin
        r_hold      <= cfg_data;
        r_hold_full <= 1'b1;
        r_bytes     <= r_bytes + 1'b1;
      end
    end
  end

  assign cfg_ready   = w_ready;
  assign prog_clk_en = w_en;
  assign ccff_head   = w_en ? w_bit : r_head_last;
  assign busy        = (r_state == LOAD);
  assign done        = (r_state == DONE);
  assign o_dbg_state = r_state;

  ccff_rb_packer #(.W(BYTE_W)) u_rb_packer (
    .clk         (prog_clk),
    .rst         (prog_reset),
    .i_clear     (w_start_ok),
    .i_bit_valid (w_en),
    .i_bit       (ccff_tail),
    .i_flush     (w_last),
    .o_data      (rb_data),
    .o_valid     (rb_valid)
  );

endmodule
